ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Width, default 8, data word width in bits.
REQ-002 AddressSize, default 4, RAM address width; RAM holds 2**AddressSize words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  producer offers in_data.
REQ-006 in_ready  output  1  controller accepts in_data this cycle.
REQ-007 in_data  input  Width  write data.
REQ-008 out_valid  output  1  out_data holds the oldest word.
REQ-009 out_ready  input  1  consumer takes out_data this cycle.
REQ-010 out_data  output  Width  registered head word.
REQ-011 count  output  AddressSize+1  words held (RAM plus output register).
REQ-012 full / empty  output  1 each  full = (mem_count==2**AddressSize) & out_valid; empty = !out_valid.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_addr  output  AddressSize  RAM address (shared by read and write).
REQ-015 ram_d  output  Width  RAM write data.
REQ-016 ram_q  input  Width  RAM combinational read data for ram_addr.

Function
REQ-017 Internal state: wr_ptr, rd_ptr (AddressSize bits, wrap modulo 2**AddressSize), mem_count (0..2**AddressSize), out_valid, out_data.
REQ-018 A transfer occurs on valid&ready at a rising edge; FIFO order is strictly preserved.
REQ-019 out_free = !out_valid | out_ready.
REQ-020 read_op = out_free & (mem_count!=0); ram_addr = rd_ptr, out_data <= ram_q, out_valid <= 1, rd_ptr+1, mem_count-1.
REQ-021 in_ready = rst & !read_op & (mem_count!=2**AddressSize); in_ready does not depend on in_valid.
REQ-022 bypass = in_valid & in_ready & out_free & (mem_count==0); out_data <= in_data, out_valid <= 1; no RAM access.
REQ-023 write_op = in_valid & in_ready & !bypass; ram_we = 1, ram_addr = wr_ptr, ram_d = in_data, wr_ptr+1, mem_count+1.
REQ-024 ram_we = write_op only; ram_d = in_data at all times; ram_addr = rd_ptr when read_op, else wr_ptr.
REQ-025 Read has priority over write: one RAM operation per cycle max; a write is stalled (in_ready=0) during any read cycle.
REQ-026 If out_ready & out_valid and neither read_op nor bypass, out_valid <= 0; out_data holds its value.
REQ-027 Invariant: out_valid==0 implies mem_count==0.
REQ-028 count = mem_count + out_valid; maximum 2**AddressSize+1.
REQ-029 Latency: word accepted into empty controller appears on out_valid/out_data the next cycle.
REQ-030 Push into full controller: in_ready=0, no state change; pop from empty: out_valid=0, no state change.

Reset
REQ-031 On a rising edge with rst=0: wr_ptr, rd_ptr, mem_count = 0; out_valid = 0; out_data = 0.
REQ-032 While rst=0: in_ready = 0 and ram_we = 0; RAM contents are not cleared by this block.
REQ-033 Reset mid-operation discards all held words; the first post-reset write uses ram_addr 0.

Verification (Width=8, AddressSize=2: 4 RAM words + 1 output register)
REQ-034 rst=0 for 2 cycles -> out_valid=0, count=0, empty=1, in_ready=0, ram_we=0; after release, in_ready=1.
REQ-035 out_ready=0, push 0xA5 -> next cycle out_valid=1, out_data=0xA5, count=1, ram_we never asserted.
REQ-036 out_ready=0, push 0x01..0x06 -> 0x01 bypassed, 0x02..0x05 written at ram_addr 0..3, count=5, full=1, in_ready=0 for 0x06.
REQ-037 From full, out_ready=1, in_valid=0 -> out_data 0x01..0x05 on 5 consecutive cycles, reads at ram_addr 0..3, in_ready=0 on each read cycle, then empty=1.
REQ-038 Random push/pop for 64 cycles with pointer wrap -> output sequence equals input sequence, count never exceeds 5, and ram_we never coincides with a read.
REQ-039 Count=3, assert rst one cycle -> count=0, out_valid=0; next push bypasses and the following write goes to ram_addr 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller that drives an external single-port RAM with one shared
//   address and combinational read data. The head word is held in a
//   registered output stage. A word that arrives while both the RAM and the
//   output stage are free bypasses the RAM and goes straight to the output.
//   The RAM does at most one access per cycle, and reads have priority.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   in_valid   : producer offers in_data
//   in_ready   : controller accepts in_data this cycle
//   in_data    : write data [Width]
//   out_valid  : out_data holds the oldest word
//   out_ready  : consumer takes out_data this cycle
//   out_data   : registered head word [Width]
//   count      : words held, RAM plus output stage [AddressSize+1]
//   full/empty : status flags
//   ram_we     : RAM write enable
//   ram_addr   : RAM address, shared by read and write [AddressSize]
//   ram_d      : RAM write data [Width]
//   ram_q      : RAM read data for ram_addr [Width]
module ram_fifo_ctrl #(
    parameter int Width       = 8,
    parameter int AddressSize = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Width-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Width-1:0]       out_data,
    output logic [AddressSize:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   ram_we,
    output logic [AddressSize-1:0] ram_addr,
    output logic [Width-1:0]       ram_d,
    input  logic [Width-1:0]       ram_q
);

    localparam logic [AddressSize:0] MemDepth = (AddressSize+1)'(2**AddressSize);

    logic [AddressSize-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddressSize-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddressSize:0]   mem_count_q, mem_count_d;
    logic                   out_valid_q, out_valid_d;
    logic [Width-1:0]       out_data_q, out_data_d;

    logic mem_empty;
    logic mem_full;
    logic out_free;
    logic read_op;
    logic bypass;
    logic write_op;

    assign mem_empty = (mem_count_q == '0);
    assign mem_full  = (mem_count_q == MemDepth);
    assign out_free  = !out_valid_q || out_ready;

    // Refill the output stage from RAM whenever it is (or is about to be) free.
    assign read_op  = out_free && !mem_empty;
    // A read owns the RAM port this cycle, so the producer is stalled.
    assign in_ready = rst && !read_op && !mem_full;
    // Nothing is queued in RAM: the new word can go straight to the output.
    assign bypass   = in_valid && in_ready && out_free && mem_empty;
    assign write_op = in_valid && in_ready && !bypass;

    assign ram_we   = write_op;
    assign ram_d    = in_data;
    assign ram_addr = read_op ? rd_ptr_q : wr_ptr_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (read_op) begin
            out_data_d  = ram_q;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
            mem_count_d = mem_count_q - 1'b1;
        end else if (bypass) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            // Head consumed with nothing to replace it; data is left as-is.
            out_valid_d = 1'b0;
        end

        // Never concurrent with read_op, since in_ready is low during reads.
        if (write_op) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            mem_count_d = mem_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = mem_count_q + {{AddressSize{1'b0}}, out_valid_q};
    assign full      = mem_full && out_valid_q;
    assign empty     = !out_valid_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl (Width=8, AddressSize=2): 4 RAM words plus
// the output stage. Directed sequences with hand-computed expectations,
// followed by a random push/pop phase checked against a queue model.
module tb_ram_fifo_ctrl;

    localparam int W = 8;
    localparam int A = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [A:0]   count;
    logic         full;
    logic         empty;
    logic         ram_we;
    logic [A-1:0] ram_addr;
    logic [W-1:0] ram_d;
    logic [W-1:0] ram_q;

    logic [W-1:0] mem [4];

    int n_tests = 0;
    int n_fail  = 0;

    ram_fifo_ctrl #(.Width(W), .AddressSize(A)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple RAM model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end
    assign ram_q = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] exp_word;
        int           wp;
        int           rp;
        int           msz;
        logic         exp_read;
        logic         exp_bypass;
        logic         exp_ir;
        logic         exp_we;
        int           guard;

        for (int i = 0; i < 4; i++) mem[i] = '0;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b0;
        #1;

        // ---------------- reset ----------------
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_in_ready2", in_ready, 0);
        check("rst_ram_we2", ram_we, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        $display("[TB] reset released");

        // ---------------- single bypass push ----------------
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        check("a5_ram_we", ram_we, 0);
        check("a5_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("a5_out_valid", out_valid, 1);
        check("a5_out_data", out_data, 8'hA5);
        check("a5_count", count, 1);
        check("a5_ram_we2", ram_we, 0);
        $display("[TB] push 0xa5 -> out_data 0x%0h", out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("a5_pop_empty", empty, 1);
        check("a5_pop_count", count, 0);
        check("a5_hold_data", out_data, 8'hA5);

        // ---------------- fill to full ----------------
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            #1;
            if (k == 1) begin
                check("fill_bypass_we", ram_we, 0);
                check("fill_bypass_ir", in_ready, 1);
            end else if (k <= 5) begin
                check("fill_we", ram_we, 1);
                check("fill_addr", ram_addr, 32'(k - 2));
                check("fill_ir", in_ready, 1);
            end else begin
                check("full_in_ready", in_ready, 0);
                check("full_ram_we", ram_we, 0);
            end
            $display("[TB] push 0x%0h in_ready=%0d ram_we=%0d addr=%0d", in_data, in_ready, ram_we, ram_addr);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("full_count", count, 5);
        check("full_flag", full, 1);
        check("full_out_data", out_data, 8'h01);

        // ---------------- drain ----------------
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, 32'(k + 1));
            check("drain_addr", ram_addr, 32'(k));
            check("drain_in_ready", in_ready, 0);
            check("drain_we", ram_we, 0);
            $display("[TB] pop 0x%0h (read addr %0d)", out_data, ram_addr);
            tick();
        end
        check("drain_last_data", out_data, 8'h05);
        check("drain_last_valid", out_valid, 1);
        check("drain_last_ir", in_ready, 1);
        $display("[TB] pop 0x%0h", out_data);
        tick();
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // ---------------- random push/pop ----------------
        // All pointers are back at 0 here (4 writes, 4 reads).
        wp = 0;
        rp = 0;
        q.delete();
        for (int cyc = 0; cyc < 64; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 45);
            in_data   = 8'($urandom);
            #1;
            msz        = (q.size() > 0) ? q.size() - 1 : 0;
            exp_read   = (q.size() == 0 || out_ready) && (msz != 0);
            exp_ir     = !exp_read && (msz != 4);
            exp_bypass = in_valid && exp_ir && (q.size() == 0 || out_ready) && (msz == 0);
            exp_we     = in_valid && exp_ir && !exp_bypass;
            check("rnd_count", count, 32'(q.size()));
            check("rnd_out_valid", out_valid, 32'(q.size() > 0));
            check("rnd_in_ready", in_ready, 32'(exp_ir));
            check("rnd_ram_we", ram_we, 32'(exp_we));
            if (ram_we && exp_read) check("rnd_we_during_read", 1, 0);
            if (count > 5) check("rnd_count_max", count, 5);
            if (exp_read) check("rnd_read_addr", ram_addr, 32'(rp));
            if (exp_we) check("rnd_write_addr", ram_addr, 32'(wp));
            if (out_valid && out_ready && q.size() > 0) begin
                exp_word = q.pop_front();
                check("rnd_order", out_data, 32'(exp_word));
                $display("[TB] rnd pop 0x%0h", out_data);
            end
            if (in_valid && exp_ir) begin
                q.push_back(in_data);
                $display("[TB] rnd push 0x%0h", in_data);
            end
            if (exp_read) rp = (rp + 1) % 4;
            if (exp_we) wp = (wp + 1) % 4;
            tick();
        end

        // Drain what is left, still checking order, with a cycle budget.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        guard = 0;
        while (out_valid && guard < 12) begin
            if (q.size() > 0) begin
                exp_word = q.pop_front();
                check("tail_order", out_data, 32'(exp_word));
            end else begin
                check("tail_extra_word", out_valid, 0);
            end
            tick();
            guard++;
        end
        check("tail_drained", out_valid, 0);
        check("tail_queue_empty", 32'(q.size()), 0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_count", count, 3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        $display("[TB] mid-operation reset");
        in_valid = 1'b1;
        in_data  = 8'h44;
        #1;
        check("post_rst_bypass_we", ram_we, 0);
        tick();
        in_data = 8'h55;
        #1;
        check("post_rst_we", ram_we, 1);
        check("post_rst_addr", ram_addr, 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_head", out_data, 8'h44);
        check("post_rst_count2", count, 2);
        check("post_rst_read_addr", ram_addr, 0);
        tick();
        check("post_rst_second", out_data, 8'h55);
        tick();
        check("post_rst_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
